// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : 2-entry valid/ready skid buffer for one pipeline stage payload,
//            with a priority hold stall, a NOP-injecting flush and a stall counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf #(
   parameter int                  DATA_W     = 32,
   parameter logic [DATA_W-1:0]   NOP_VAL    = {DATA_W{1'b0}},
   parameter int                  HOLD_W     = 3,
   parameter logic [HOLD_W-1:0]   HOLD_LEVEL = 3'd2,
   parameter int                  CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [HOLD_W-1:0] hold_flag_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [1:0]        occupancy_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic [DATA_W-1:0] w_main_nxt;
   logic [DATA_W-1:0] w_skid_nxt;
   logic              r_in_ready;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_hold;
   logic              w_deq;
   logic              w_enq;
   logic              w_out_valid;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_hold      = (hold_flag_i >= HOLD_LEVEL);
   assign w_deq       = w_out_valid & out_ready_i & ~w_hold & ~flush_i;
   assign w_enq       = in_valid_i & r_in_ready & ~flush_i;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush_i) begin
         w_state_nxt = ST_EMPTY;
         w_main_nxt  = NOP_VAL;
         w_skid_nxt  = NOP_VAL;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_enq) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = in_data_i;
               end
            end
            ST_ONE: begin
               if (w_enq && w_deq) begin
                  w_main_nxt  = in_data_i;
               end else if (w_enq) begin
                  w_state_nxt = ST_TWO;
                  w_skid_nxt  = in_data_i;
               end else if (w_deq) begin
                  w_state_nxt = ST_EMPTY;
                  w_main_nxt  = NOP_VAL;
               end
            end
            ST_TWO: begin
               // in_ready is low here, so only the drain path exists
               if (w_deq) begin
                  w_state_nxt = ST_ONE;
                  w_main_nxt  = r_skid;
                  w_skid_nxt  = NOP_VAL;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_main_nxt  = NOP_VAL;
               w_skid_nxt  = NOP_VAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_EMPTY;
         r_main      <= NOP_VAL;
         r_skid      <= NOP_VAL;
         r_in_ready  <= 1'b1;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         // registered from next state so upstream never sees out_ready_i combinationally
         r_in_ready <= (w_state_nxt != ST_TWO);
         if (w_out_valid && !w_deq && !flush_i && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign in_ready_o  = r_in_ready;
   assign out_valid_o = w_out_valid;
   assign out_data_o  = w_out_valid ? r_main : NOP_VAL;
   assign occupancy_o = r_state;
   assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : randomized and directed bench for pipe_stage_buf against a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_buf;

   localparam int          c_data_w = 32;
   localparam logic [31:0] c_nop    = 32'hDEAD_BEEF;
   localparam int          c_cnt_w  = 4;

   logic              clk;
   logic              rst;
   logic              flush_i;
   logic [2:0]        hold_flag_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [31:0]       in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [31:0]       out_data_o;
   logic [1:0]        occupancy_o;
   logic [c_cnt_w-1:0] stall_cnt_o;

   pipe_stage_buf #(
      .DATA_W     (c_data_w),
      .NOP_VAL    (c_nop),
      .HOLD_W     (3),
      .HOLD_LEVEL (3'd2),
      .CNT_W      (c_cnt_w)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .hold_flag_i (hold_flag_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .occupancy_o (occupancy_o),
      .stall_cnt_o (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   // reference model: a plain FIFO of at most two payloads
   logic [31:0] m_q[$];
   logic        m_rdy;
   int          m_stall;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rdy   = 1'b1;
      m_stall = 0;
   endtask

   task automatic check_all();
      check_val("out_valid", {31'd0, out_valid_o}, {31'd0, m_q.size() != 0});
      check_val("out_data", out_data_o, (m_q.size() != 0) ? m_q[0] : c_nop);
      check_val("occupancy", {30'd0, occupancy_o}, m_q.size());
      check_val("in_ready", {31'd0, in_ready_o}, {31'd0, m_rdy});
      check_val("stall_cnt", {28'd0, stall_cnt_o}, m_stall);
   endtask

   task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                       input logic [2:0] hf, input logic fl);
      logic hold, deq, enq;
      @(negedge clk);
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = ordy;
      hold_flag_i = hf;
      flush_i     = fl;
      hold = (hf >= 3'd2);
      deq  = (m_q.size() != 0) && ordy && !hold && !fl;
      enq  = v && m_rdy && !fl;
      @(posedge clk);
      if ((m_q.size() != 0) && !deq && !fl && (m_stall < (1 << c_cnt_w) - 1))
         m_stall++;
      if (fl) begin
         m_q.delete();
      end else begin
         if (deq) void'(m_q.pop_front());
         if (enq) m_q.push_back(d);
      end
      m_rdy = (m_q.size() < 2);
      #1;
      check_all();
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst         = 1'b0;
      flush_i     = 1'b0;
      hold_flag_i = '0;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b1;

      // back-to-back stream
      step(1, 32'h11, 1, 0, 0);
      step(1, 32'h22, 1, 0, 0);
      step(1, 32'h33, 1, 0, 0);
      step(1, 32'h44, 1, 0, 0);
      step(0, 32'h0,  1, 0, 0);

      // downstream stall fills the skid, then drains in order
      step(1, 32'hA1, 0, 0, 0);
      step(1, 32'hA2, 0, 0, 0);
      step(1, 32'hA3, 0, 0, 0);
      step(1, 32'hA3, 1, 0, 0);
      step(1, 32'hA3, 1, 0, 0);
      repeat (3) step(0, 32'h0, 1, 0, 0);

      // hold blocks dequeue only
      step(1, 32'h55, 0, 0, 0);
      repeat (3) step(1, 32'h66, 1, 3'd2, 0);
      repeat (3) step(0, 32'h0, 1, 3'd1, 0);

      // flush with hold and a presented input
      step(1, 32'h71, 0, 0, 0);
      step(1, 32'h72, 0, 0, 0);
      step(1, 32'h77, 1, 3'd3, 1);
      step(0, 32'h0,  1, 0, 0);

      // stall counter saturation
      step(1, 32'h5A, 0, 0, 0);
      repeat ((1 << c_cnt_w) + 5) step(0, 32'h0, 0, 0, 0);
      step(0, 32'h0, 0, 3'd7, 1);

      // async reset while full
      step(1, 32'hC1, 0, 0, 0);
      step(1, 32'hC2, 0, 0, 0);
      async_reset();

      for (int i = 0; i < 2000; i++) begin
         logic [2:0] hf;
         hf = (($urandom % 4) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
         step(($urandom % 4) != 0, $urandom, ($urandom % 5) != 0, hf, ($urandom % 16) == 0);
         if ((i % 250) == 249) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
